deint_result: RTL

Downstream capture stage for the dual-slope voltmeter measurement FSM.
- Watches the FSM's AFE phase select and the analog comparator.
- Counts clock cycles during the deintegrate phase until the integrator crosses zero, then latches the count with sign and range.
- Presents the latched result to the readout/display logic through a valid/ready handshake, flagging overrange and dropped results.

---
 rtl/deint_result_if.sv | 27 ++
 rtl/deint_result.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/deint_result_if.sv
// Handshake bundle between the dual-slope phase sequencer, the deintegrate
// capture stage and the readout logic. master = capture stage, slave = its environment.
interface deint_result_if #(
   parameter int COUNT_W = 16
);
   logic [1:0]         afe_sel_i;
   logic               comp_i;
   logic               ref_sign_i;
   logic [2:0]         range_sel_i;
   logic [COUNT_W-1:0] result_o;
   logic               sign_o;
   logic [2:0]         range_o;
   logic               overrange_o;
   logic               valid_o;
   logic               ready_i;
   logic               overrun_o;

   modport master (
      input  afe_sel_i, comp_i, ref_sign_i, range_sel_i, ready_i,
      output result_o, sign_o, range_o, overrange_o, valid_o, overrun_o
   );

   modport slave (
      output afe_sel_i, comp_i, ref_sign_i, range_sel_i, ready_i,
      input  result_o, sign_o, range_o, overrange_o, valid_o, overrun_o
   );
endinterface

// File: rtl/deint_result.sv
// Deintegrate-phase counter and result capture for the dual-slope voltmeter.
// Optional batch averaging of conversions is enabled with `define DEINT_AVG_EN.
//
// state | meaning
// IDLE  | waiting for the deintegrate phase (afe_sel == 11)
// ARM   | clear counter, capture comparator polarity, sign and range
// COUNT | count until the comparator flips or the count saturates
// HOLD  | conversion done, wait for the phase to leave deintegrate
module deint_result #(
   parameter int          COUNT_W   = 16,
   parameter int unsigned MAX_COUNT = 16'hFFFF,
   parameter int          AVG_LOG2  = 2
) (
   input logic           clk_i,
   input logic           rst_i,
   deint_result_if.master bus
);
   localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_HOLD} state_t;

   state_t             state;
   logic [1:0]         comp_sync;
   logic               comp_s;
   logic               deint;
   logic [COUNT_W-1:0] count;
   logic               pol;
   logic               sh_sign;
   logic [2:0]         sh_range;

   logic               conv_done;
   logic [COUNT_W-1:0] conv_val;
   logic               conv_sign;
   logic [2:0]         conv_range;
   logic               conv_ovr;

   logic               pres;
   logic [COUNT_W-1:0] pres_val;
   logic               pres_sign;
   logic [2:0]         pres_range;
   logic               pres_ovr;

   logic [COUNT_W-1:0] result_q;
   logic               sign_q;
   logic [2:0]         range_q;
   logic               ovr_q;
   logic               valid_q;
   logic               overrun_q;

   assign comp_s = comp_sync[1];
   assign deint  = (bus.afe_sel_i == 2'b11);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         comp_sync  <= 2'b00;
         count      <= '0;
         pol        <= 1'b0;
         sh_sign    <= 1'b0;
         sh_range   <= 3'd0;
         conv_done  <= 1'b0;
         conv_val   <= '0;
         conv_sign  <= 1'b0;
         conv_range <= 3'd0;
         conv_ovr   <= 1'b0;
      end else begin
         comp_sync <= {comp_sync[0], bus.comp_i};
         conv_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (deint) state <= S_ARM;
            end
            S_ARM: begin
               if (!deint) begin
                  state <= S_IDLE;
               end else begin
                  count    <= '0;
                  pol      <= comp_s;
                  sh_sign  <= bus.ref_sign_i;
                  sh_range <= bus.range_sel_i;
                  state    <= S_COUNT;
               end
            end
            S_COUNT: begin
               // a zero crossing on the saturating cycle still wins over overrange
               if (!deint) begin
                  state <= S_IDLE;
               end else if (comp_s != pol) begin
                  conv_done  <= 1'b1;
                  conv_val   <= count;
                  conv_ovr   <= 1'b0;
                  conv_sign  <= sh_sign;
                  conv_range <= sh_range;
                  state      <= S_HOLD;
               end else if (count == MAX_C) begin
                  conv_done  <= 1'b1;
                  conv_val   <= MAX_C;
                  conv_ovr   <= 1'b1;
                  conv_sign  <= sh_sign;
                  conv_range <= sh_range;
                  state      <= S_HOLD;
               end else begin
                  count <= count + 1'b1;
               end
            end
            S_HOLD: begin
               if (!deint) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DEINT_AVG_EN
   localparam int ACC_W = COUNT_W + 1 + AVG_LOG2;
   localparam int N_W   = AVG_LOG2 + 1;
   localparam logic [N_W-1:0] BATCH = N_W'(1 << AVG_LOG2);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] conv_ext;
   logic signed [ACC_W-1:0] conv_s;
   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] avg;
   logic        [ACC_W-1:0] mag;
   logic        [N_W-1:0]   n;
   logic        [N_W-1:0]   n_next;
   logic        [2:0]       batch_range;
   logic                    restart;
   logic                    batch_full;

   always_comb begin
      conv_ext   = signed'({{(ACC_W-COUNT_W){1'b0}}, conv_val});
      conv_s     = conv_sign ? -conv_ext : conv_ext;
      restart    = (n == '0) || (conv_range != batch_range);
      base       = acc;
      n_next     = n + 1'b1;
      if (restart) begin
         base   = '0;
         n_next = N_W'(1);
      end
      sum        = base + conv_s;
      avg        = sum >>> AVG_LOG2;
      mag        = avg[ACC_W-1] ? -avg : avg;
      batch_full = (n_next == BATCH);
      pres       = conv_done && (conv_ovr || batch_full);
      pres_range = conv_range;
      if (conv_ovr) begin
         pres_val  = conv_val;
         pres_sign = conv_sign;
         pres_ovr  = 1'b1;
      end else begin
         pres_val  = (|mag[ACC_W-1:COUNT_W]) ? '1 : mag[COUNT_W-1:0];
         pres_sign = avg[ACC_W-1];
         pres_ovr  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc         <= '0;
         n           <= '0;
         batch_range <= 3'd0;
      end else if (conv_done) begin
         if (conv_ovr || batch_full) begin
            acc <= '0;
            n   <= '0;
         end else begin
            acc         <= sum;
            n           <= n_next;
            batch_range <= conv_range;
         end
      end
   end
`else
   always_comb begin
      pres       = conv_done;
      pres_val   = conv_val;
      pres_sign  = conv_sign;
      pres_range = conv_range;
      pres_ovr   = conv_ovr;
   end
`endif

   // a new result in the same cycle as consumption is a clean handover, not an overrun
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_q  <= '0;
         sign_q    <= 1'b0;
         range_q   <= 3'd0;
         ovr_q     <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else if (pres) begin
         result_q <= pres_val;
         sign_q   <= pres_sign;
         range_q  <= pres_range;
         ovr_q    <= pres_ovr;
         valid_q  <= 1'b1;
         if (valid_q && !bus.ready_i) overrun_q <= 1'b1;
         else if (valid_q)            overrun_q <= 1'b0;
      end else if (valid_q && bus.ready_i) begin
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end
   end

   assign bus.result_o    = result_q;
   assign bus.sign_o      = sign_q;
   assign bus.range_o     = range_q;
   assign bus.overrange_o = ovr_q;
   assign bus.valid_o     = valid_q;
   assign bus.overrun_o   = overrun_q;
endmodule
